// File: rtl/regfile_sb.sv
// regfile_sb: general-purpose register file with a per-register pending-write
// scoreboard. x0 is hardwired to zero.
// Reads and stall_o are combinational. pending_cnt_o is registered.
// Optional build macro REGFILE_BYPASS_EN: a same-cycle writeback forwards its
// data to a matching read port and masks that port's hazard.

`ifndef RADDR_WIDTH
`define RADDR_WIDTH 5
`endif
`ifndef RDATA_WIDTH
`define RDATA_WIDTH 32
`endif

module regfile_sb #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned AW       = `RADDR_WIDTH,
  parameter int unsigned DW       = `RDATA_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] reg1_raddr_i,
  input  logic          reg1_re_i,
  input  logic [AW-1:0] reg2_raddr_i,
  input  logic          reg2_re_i,
  output logic [DW-1:0] reg1_rdata_o,
  output logic [DW-1:0] reg2_rdata_o,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          issue_valid_i,
  input  logic          issue_we_i,
  input  logic [AW-1:0] issue_waddr_i,
  output logic          stall_o,
  output logic [AW:0]   pending_cnt_o
);

  localparam int unsigned CW = AW + 1;

  logic [DW-1:0]       regs [NUM_REGS];
  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] pending_nxt;
  logic [CW-1:0]       cnt_nxt;
  logic                wr_act;
  logic                hit1;
  logic                hit2;
  logic                haz1;
  logic                haz2;

  assign wr_act = we_i && (waddr_i != '0);

  // Same-cycle writeback match per read port (only with forwarding built in)
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
`ifdef REGFILE_BYPASS_EN
    hit1 = wr_act && (waddr_i == reg1_raddr_i);
    hit2 = wr_act && (waddr_i == reg2_raddr_i);
`endif
  end

  // Read ports: zero for disabled port or x0, forwarded data on a bypass hit
  always_comb begin
    reg1_rdata_o = '0;
    reg2_rdata_o = '0;
    if (reg1_re_i && (reg1_raddr_i != '0)) begin
      reg1_rdata_o = hit1 ? wdata_i : regs[reg1_raddr_i];
    end
    if (reg2_re_i && (reg2_raddr_i != '0)) begin
      reg2_rdata_o = hit2 ? wdata_i : regs[reg2_raddr_i];
    end
  end

  // Read-after-write hazard against a pending destination
  always_comb begin
    haz1    = reg1_re_i && (reg1_raddr_i != '0) && pending[reg1_raddr_i] && !hit1;
    haz2    = reg2_re_i && (reg2_raddr_i != '0) && pending[reg2_raddr_i] && !hit2;
    stall_o = haz1 || haz2;
  end

  // Next scoreboard state: clear on writeback, then set on issue so set wins
  always_comb begin
    pending_nxt = pending;
    if (wr_act) begin
      pending_nxt[waddr_i] = 1'b0;
    end
    if (issue_valid_i && issue_we_i && (issue_waddr_i != '0) && !stall_o) begin
      pending_nxt[issue_waddr_i] = 1'b1;
    end
    pending_nxt[0] = 1'b0;
    cnt_nxt = '0;
    for (int i = 1; i < int'(NUM_REGS); i++) begin
      cnt_nxt = cnt_nxt + CW'(pending_nxt[i]);
    end
  end

  // Scoreboard bits and their population count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending       <= '0;
      pending_cnt_o <= '0;
    end else begin
      pending       <= pending_nxt;
      pending_cnt_o <= cnt_nxt;
    end
  end

  // Register array write port; x0 never written
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs[i] <= '0;
      end
    end else if (wr_act) begin
      regs[waddr_i] <= wdata_i;
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb (both with and without
// REGFILE_BYPASS_EN; expectations follow the macro).

module tb_regfile_sb;

  logic        clk;
  logic        rst_n;
  logic [4:0]  reg1_raddr;
  logic        reg1_re;
  logic [4:0]  reg2_raddr;
  logic        reg2_re;
  logic [31:0] reg1_rdata;
  logic [31:0] reg2_rdata;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        issue_valid;
  logic        issue_we;
  logic [4:0]  issue_waddr;
  logic        stall;
  logic [5:0]  pending_cnt;

  int checks;
  int errors;

  regfile_sb dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .reg1_raddr_i  (reg1_raddr),
    .reg1_re_i     (reg1_re),
    .reg2_raddr_i  (reg2_raddr),
    .reg2_re_i     (reg2_re),
    .reg1_rdata_o  (reg1_rdata),
    .reg2_rdata_o  (reg2_rdata),
    .we_i          (we),
    .waddr_i       (waddr),
    .wdata_i       (wdata),
    .issue_valid_i (issue_valid),
    .issue_we_i    (issue_we),
    .issue_waddr_i (issue_waddr),
    .stall_o       (stall),
    .pending_cnt_o (pending_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a1, input logic e1, input logic [4:0] a2, input logic e2);
    reg1_raddr = a1;
    reg1_re    = e1;
    reg2_raddr = a2;
    reg2_re    = e2;
    #1;
  endtask

  task automatic issue(input logic [4:0] a);
    issue_valid = 1'b1;
    issue_we    = 1'b1;
    issue_waddr = a;
    tick();
    issue_valid = 1'b0;
    issue_we    = 1'b0;
    issue_waddr = '0;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    we    = 1'b1;
    waddr = a;
    wdata = d;
    tick();
    we    = 1'b0;
    waddr = '0;
    wdata = '0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    reg1_raddr = '0; reg1_re = 1'b0; reg2_raddr = '0; reg2_re = 1'b0;
    we = 1'b0; waddr = '0; wdata = '0;
    issue_valid = 1'b0; issue_we = 1'b0; issue_waddr = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Reset state
    chk("rst_cnt", 32'(pending_cnt), 32'd0);
    for (int i = 1; i < 32; i++) begin
      rd(5'(i), 1'b1, 5'(i), 1'b1);
      chk("rst_rd1", reg1_rdata, 32'd0);
      chk("rst_rd2", reg2_rdata, 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
    end
    rd(5'd0, 1'b0, 5'd0, 1'b0);

    // Basic write and read
    wb(5'd5, 32'hDEADBEEF);
    rd(5'd5, 1'b1, 5'd0, 1'b1);
    chk("rw_x5", reg1_rdata, 32'hDEADBEEF);
    chk("rw_x0", reg2_rdata, 32'd0);
    rd(5'd5, 1'b0, 5'd5, 1'b1);
    chk("rw_re0", reg1_rdata, 32'd0);
    chk("rw_p2", reg2_rdata, 32'hDEADBEEF);
    wb(5'd0, 32'h1234);
    rd(5'd0, 1'b1, 5'd0, 1'b1);
    chk("x0_wr", reg1_rdata, 32'd0);
    chk("x0_cnt", 32'(pending_cnt), 32'd0);

    // Hazard lifecycle on x7
    rd(5'd0, 1'b0, 5'd0, 1'b0);
    issue(5'd7);
    chk("haz_cnt1", 32'(pending_cnt), 32'd1);
    rd(5'd7, 1'b1, 5'd0, 1'b0);
    chk("haz_stall", 32'(stall), 32'd1);
    rd(5'd7, 1'b0, 5'd0, 1'b0);
    chk("haz_nore", 32'(stall), 32'd0);
    wb(5'd7, 32'h55);
    rd(5'd7, 1'b1, 5'd7, 1'b1);
    chk("haz_clr", 32'(stall), 32'd0);
    chk("haz_data", reg1_rdata, 32'h55);
    chk("haz_cnt0", 32'(pending_cnt), 32'd0);

    // Read of x9 during its own writeback
    rd(5'd0, 1'b0, 5'd0, 1'b0);
    issue(5'd9);
    chk("byp_cnt1", 32'(pending_cnt), 32'd1);
    we = 1'b1; waddr = 5'd9; wdata = 32'hA5A5A5A5;
    rd(5'd0, 1'b0, 5'd9, 1'b1);
`ifdef REGFILE_BYPASS_EN
    chk("byp_stall", 32'(stall), 32'd0);
    chk("byp_data", reg2_rdata, 32'hA5A5A5A5);
`else
    chk("byp_stall", 32'(stall), 32'd1);
    chk("byp_data", reg2_rdata, 32'd0);
`endif
    tick();
    we = 1'b0; waddr = '0; wdata = '0;
    #1;
    chk("byp_next", reg2_rdata, 32'hA5A5A5A5);
    chk("byp_nstall", 32'(stall), 32'd0);
    chk("byp_cnt0", 32'(pending_cnt), 32'd0);

    // Set/clear collision on x3: set wins
    rd(5'd0, 1'b0, 5'd0, 1'b0);
    issue(5'd3);
    we = 1'b1; waddr = 5'd3; wdata = 32'h33;
    issue(5'd3);
    we = 1'b0; waddr = '0; wdata = '0;
    chk("col_cnt", 32'(pending_cnt), 32'd1);
    rd(5'd3, 1'b1, 5'd0, 1'b0);
    chk("col_stall", 32'(stall), 32'd1);

    // Issue while stalled reserves nothing
    issue(5'd4);
    chk("stl_cnt", 32'(pending_cnt), 32'd1);
    rd(5'd0, 1'b0, 5'd4, 1'b1);
    chk("stl_x4", 32'(stall), 32'd0);

    // Async reset in the middle of a stall
    rd(5'd0, 1'b0, 5'd0, 1'b0);
    issue(5'd2);
    chk("ar_cnt2", 32'(pending_cnt), 32'd2);
    rd(5'd3, 1'b1, 5'd5, 1'b1);
    chk("ar_stall", 32'(stall), 32'd1);
    chk("ar_x5", reg2_rdata, 32'hDEADBEEF);
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar_nstall", 32'(stall), 32'd0);
    chk("ar_cnt0", 32'(pending_cnt), 32'd0);
    chk("ar_rd1", reg1_rdata, 32'd0);
    chk("ar_rd2", reg2_rdata, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("ar_post", 32'(stall), 32'd0);
    chk("ar_pcnt", 32'(pending_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- General-purpose register file: the responder for the ID-stage register read requests (reg1/reg2 raddr + re) and the target of the WB-stage write port.
- Adds a per-register pending-write scoreboard. Long-latency destinations (loads, multi-cycle ops) are reserved at issue, and the block raises a stall when a decoder reads a register whose write has not yet retired.
- Sits between the ID decoders and the WB stage, in the core's id/ directory alongside the decoders.

Parameters:
- NUM_REGS, 32, number of architectural registers; x0 is hardwired to zero.
- AW, `RADDR_WIDTH (5), register address width.
- DW, `RDATA_WIDTH (32), register data width.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- reg1_raddr_i  in  AW  read port 1 address.
- reg1_re_i  in  1  read port 1 enable.
- reg2_raddr_i  in  AW  read port 2 address.
- reg2_re_i  in  1  read port 2 enable.
- reg1_rdata_o  out  DW  read port 1 data.
- reg2_rdata_o  out  DW  read port 2 data.
- we_i  in  1  writeback enable.
- waddr_i  in  AW  writeback address.
- wdata_i  in  DW  writeback data.
- issue_valid_i  in  1  ID is issuing an instruction this cycle.
- issue_we_i  in  1  the issued instruction has a long-latency destination to reserve.
- issue_waddr_i  in  AW  destination being reserved.
- stall_o  out  1  read-after-write hazard on a pending register; hold ID.
- pending_cnt_o  out  AW+1  number of registers currently pending.

Behaviour:
- Reset (async, rst_n=0):
  - All registers cleared to 0; all pending bits cleared; pending_cnt_o=0.
  - Read data is therefore 0 and stall_o=0.
- Write:
  - At posedge, if we_i && waddr_i!=0, regs[waddr_i] <= wdata_i.
  - Writes to x0 are ignored.
- Read (combinational, zero-cycle latency):
  - rdataN = 0 when reN=0 or raddrN=0.
  - Otherwise regs[raddrN], subject to the bypass rule below.
- Scoreboard set:
  - At posedge, pending[issue_waddr_i] <= 1 when issue_valid_i && issue_we_i && issue_waddr_i!=0 && !stall_o.
  - A stalled issue reserves nothing.
- Scoreboard clear:
  - At posedge, pending[waddr_i] <= 0 when we_i && waddr_i!=0.
  - Writeback clears the bit whether or not it was set.
- Simultaneous set and clear of the same register: set wins (the new producer supersedes the retiring one).
- pending_cnt_o:
  - Registered population count of the pending bits, updated in the same edge as the bits.
  - Range 0..31; never counts x0.
- stall_o:
  - Combinational: OR over ports N of (reN && raddrN!=0 && pending[raddrN] && !bypass_hitN).
  - bypass_hitN = we_i && waddr_i==raddrN when REGFILE_BYPASS_EN is defined; otherwise 0.
- Write-after-write: issuing to an already-pending register is legal. The bit stays set until a writeback to that register.
- Reset mid-operation: all pending reservations are dropped immediately and stall_o deasserts asynchronously.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - A same-cycle writeback forwards to a matching read port: rdataN = wdata_i when we_i && waddr_i==raddrN && raddrN!=0 && reN.
  - The matching pending bit does not cause a stall in that cycle.
- Undefined:
  - Reads return the pre-write array value.
  - A read of a register being written this cycle stalls if pending, or returns old data if not pending.
  - The new value is visible from the next cycle.

Test Plan:
- Reset: hold rst_n=0, then release; read x1..x31 on both ports -> all 0, stall_o=0, pending_cnt_o=0.
- Basic R/W:
  - Write x5=32'hDEADBEEF, then read port1=x5, port2=x0 next cycle -> reg1_rdata_o=32'hDEADBEEF, reg2_rdata_o=0.
  - Write x0=32'h1234 -> x0 still reads 0.
- Hazard lifecycle:
  - Issue reserve x7 -> pending_cnt_o=1.
  - Next cycle read x7 with re=1 -> stall_o=1; read x7 with re=0 -> stall_o=0.
  - Writeback x7=32'h55 -> stall_o=0 next cycle, data 32'h55, pending_cnt_o=0.
- Bypass:
  - Pending x9; same cycle we_i=1, waddr_i=9, wdata_i=32'hA5A5A5A5, read x9.
  - With REGFILE_BYPASS_EN: stall_o=0, rdata=32'hA5A5A5A5.
  - Without: stall_o=1; the following cycle reads 32'hA5A5A5A5 with stall_o=0.
- Set/clear collision and stalled issue:
  - Pending x3; same cycle writeback x3 and issue reserve x3 -> x3 remains pending, pending_cnt_o=1.
  - Issue reserve x4 while stall_o=1 -> x4 not pending.
- Async reset mid-stall: pending x2, x3 with stall asserted; pulse rst_n low between edges -> stall_o drops immediately, pending_cnt_o=0, registers read 0.
